mtrx_fb_ctrl: RTL and testbench



---
 rtl/mtrx_pkg.sv | 25 ++
 rtl/mtrx_fill_engine.sv | 85 ++++++++
 rtl/mtrx_fb_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mtrx_fb_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtrx_pkg.sv
// Shared definitions for the LED matrix frame buffer side-bus controller:
// register offsets, STATUS bit positions and the fill engine state type.
package mtrx_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 12;

    localparam logic [15:0] OFS_ADDR     = 16'd0;
    localparam logic [15:0] OFS_DATA     = 16'd1;
    localparam logic [15:0] OFS_SELECT   = 16'd2;
    localparam logic [15:0] OFS_FILL_CNT = 16'd3;
    localparam logic [15:0] OFS_FILL_GO  = 16'd4;
    localparam logic [15:0] OFS_STATUS   = 16'd5;

    localparam int ST_BUSY   = 0;
    localparam int ST_SWAP   = 1;
    localparam int ST_CUR    = 2;
    localparam int ST_REJECT = 3;

    typedef enum logic {
        FILL_IDLE,
        FILL_RUN
    } fill_state_t;

endpackage

// File: rtl/mtrx_fill_engine.sv
// Fill engine: paints a run of pixels with one colour, offering one write per cycle
// one cycle ahead of the frame buffer port; a stall holds the run without losing a pixel.
module mtrx_fill_engine
    import mtrx_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_base,
    input  logic [ADDR_W-1:0] start_cnt,
    input  logic [DATA_W-1:0] start_colour,
    input  logic              stall,
    output logic              busy,
    output logic              issue,
    output logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] issue_data
);

    fill_state_t       state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W:0]   remain, remain_nxt;
    logic [DATA_W-1:0] colour, colour_nxt;
    logic [ADDR_W:0]   full_cnt;

    // A zero count stands for the whole frame buffer.
    assign full_cnt = (start_cnt == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, start_cnt};
    assign busy     = (state == FILL_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FILL_IDLE;
            ptr    <= '0;
            remain <= '0;
            colour <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            remain <= remain_nxt;
            colour <= colour_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        remain_nxt = remain;
        colour_nxt = colour;
        issue      = 1'b0;
        issue_addr = ptr;
        issue_data = colour;
        case (state)
            FILL_IDLE: begin
                if (start) begin
                    state_nxt  = FILL_RUN;
                    colour_nxt = start_colour;
                    issue_addr = start_base;
                    issue_data = start_colour;
                    if (stall) begin
                        ptr_nxt    = start_base;
                        remain_nxt = full_cnt;
                    end else begin
                        issue      = 1'b1;
                        ptr_nxt    = start_base + 1'b1;
                        remain_nxt = full_cnt - 1'b1;
                    end
                end
            end
            FILL_RUN: begin
                // Stay busy through the cycle carrying the last pixel.
                if (remain == '0) begin
                    state_nxt = FILL_IDLE;
                end else if (!stall) begin
                    issue      = 1'b1;
                    ptr_nxt    = ptr + 1'b1;
                    remain_nxt = remain - 1'b1;
                end
            end
            default: state_nxt = FILL_IDLE;
        endcase
    end

endmodule

// File: rtl/mtrx_fb_ctrl.sv
// Side-bus controller for the LED matrix frame buffer write port: host registers,
// arbitration between host writes and the fill engine, read path and buffer swap sequencing.
module mtrx_fb_ctrl
    import mtrx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'd8,
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int          DATA_W    = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sb_wr,
    input  logic              sb_rd,
    input  logic [15:0]       sb_addr,
    input  logic [15:0]       sb_wr_data,
    output logic [15:0]       sb_rd_data,
    output logic              sb_rd_hit,
    output logic              mtrx_wr,
    output logic [ADDR_W-1:0] mtrx_wr_addr,
    output logic [DATA_W-1:0] mtrx_wr_data,
    output logic              buffer_select,
    input  logic              buffer_current,
    output logic              busy
);

    logic [15:0]       ofs;
    logic              in_range;
    logic              wr_addr, wr_data, wr_select, wr_cnt, wr_go;
    logic              fill_start, fill_rej, rd_status;
    logic [ADDR_W-1:0] host_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic              req_sel;
    logic              fill_reject;
    logic              swap_pending;
    logic              fill_issue;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic [15:0]       rd_val;
    logic              rd_valid;

    // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
    assign ofs       = sb_addr - BASE_ADDR;
    assign in_range  = (sb_addr >= BASE_ADDR) && (ofs <= OFS_STATUS);
    assign wr_addr   = sb_wr && in_range && (ofs == OFS_ADDR);
    assign wr_data   = sb_wr && in_range && (ofs == OFS_DATA);
    assign wr_select = sb_wr && in_range && (ofs == OFS_SELECT);
    assign wr_cnt    = sb_wr && in_range && (ofs == OFS_FILL_CNT);
    assign wr_go     = sb_wr && in_range && (ofs == OFS_FILL_GO);
    assign rd_status = sb_rd && in_range && (ofs == OFS_STATUS);

    assign fill_start   = wr_go && !busy;
    assign fill_rej     = wr_go && busy;
    assign swap_pending = (req_sel != buffer_select) || (buffer_select != buffer_current);

    mtrx_fill_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk          (clk),
        .rst          (rst),
        .start        (fill_start),
        .start_base   (host_ptr),
        .start_cnt    (fill_cnt),
        .start_colour (sb_wr_data[DATA_W-1:0]),
        .stall        (wr_data),
        .busy         (busy),
        .issue        (fill_issue),
        .issue_addr   (fill_addr),
        .issue_data   (fill_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_ptr      <= '0;
            fill_cnt      <= '0;
            req_sel       <= 1'b0;
            buffer_select <= 1'b0;
            fill_reject   <= 1'b0;
        end else begin
            if (wr_addr) begin
                host_ptr <= sb_wr_data[ADDR_W-1:0];
            end else if (wr_data) begin
                host_ptr <= host_ptr + 1'b1;
            end
            if (wr_cnt) begin
                fill_cnt <= sb_wr_data[ADDR_W-1:0];
            end
            if (wr_select) begin
                req_sel <= sb_wr_data[0];
            end
            // A swap only lands while no fill is running or being launched.
            if (!busy && !fill_start) begin
                buffer_select <= req_sel;
            end
            if (fill_rej) begin
                fill_reject <= 1'b1;
            end else if (rd_status) begin
                fill_reject <= 1'b0;
            end
        end
    end

    // Host data writes win the port; the fill engine is stalled in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtrx_wr      <= 1'b0;
            mtrx_wr_addr <= '0;
            mtrx_wr_data <= '0;
        end else if (wr_data) begin
            mtrx_wr      <= 1'b1;
            mtrx_wr_addr <= host_ptr;
            mtrx_wr_data <= sb_wr_data[DATA_W-1:0];
        end else if (fill_issue) begin
            mtrx_wr      <= 1'b1;
            mtrx_wr_addr <= fill_addr;
            mtrx_wr_data <= fill_data;
        end else begin
            mtrx_wr <= 1'b0;
        end
    end

    always_comb begin
        rd_val   = 16'h0000;
        rd_valid = 1'b0;
        if (in_range) begin
            case (ofs)
                OFS_ADDR: begin
                    rd_val   = 16'(host_ptr);
                    rd_valid = 1'b1;
                end
                OFS_SELECT: begin
                    rd_val   = {13'b0, swap_pending, buffer_current, buffer_select};
                    rd_valid = 1'b1;
                end
                OFS_FILL_CNT: begin
                    rd_val   = 16'(fill_cnt);
                    rd_valid = 1'b1;
                end
                OFS_STATUS: begin
                    rd_val   = {12'b0, fill_reject, buffer_current, swap_pending, busy};
                    rd_valid = 1'b1;
                end
                default: begin
                    rd_val   = 16'h0000;
                    rd_valid = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_rd_data <= 16'hFFFF;
            sb_rd_hit  <= 1'b0;
        end else if (sb_rd) begin
            sb_rd_hit <= rd_valid;
            if (rd_valid) begin
                sb_rd_data <= rd_val;
            end
        end else begin
            sb_rd_hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mtrx_fb_ctrl.sv
// Directed self-checking bench for mtrx_fb_ctrl: register access, host writes,
// fill runs with stalls and rejects, swap sequencing and reset behaviour.
module tb_mtrx_fb_ctrl;

    localparam logic [15:0] BASE = 16'd8;

    logic        clk;
    logic        rst;
    logic        sb_wr;
    logic        sb_rd;
    logic [15:0] sb_addr;
    logic [15:0] sb_wr_data;
    logic [15:0] sb_rd_data;
    logic        sb_rd_hit;
    logic        mtrx_wr;
    logic [13:0] mtrx_wr_addr;
    logic [11:0] mtrx_wr_data;
    logic        buffer_select;
    logic        buffer_current;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mtrx_fb_ctrl #(
        .BASE_ADDR (BASE),
        .ADDR_W    (14),
        .DATA_W    (12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sb_wr          (sb_wr),
        .sb_rd          (sb_rd),
        .sb_addr        (sb_addr),
        .sb_wr_data     (sb_wr_data),
        .sb_rd_data     (sb_rd_data),
        .sb_rd_hit      (sb_rd_hit),
        .mtrx_wr        (mtrx_wr),
        .mtrx_wr_addr   (mtrx_wr_addr),
        .mtrx_wr_data   (mtrx_wr_data),
        .buffer_select  (buffer_select),
        .buffer_current (buffer_current),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers start and end on a falling edge; outputs are sampled there too.
    task automatic sb_write(input logic [15:0] ofs, input logic [15:0] d);
        sb_wr      = 1'b1;
        sb_addr    = BASE + ofs;
        sb_wr_data = d;
        @(negedge clk);
        sb_wr = 1'b0;
    endtask

    task automatic sb_read(input logic [15:0] ofs, output logic [15:0] d, output logic h);
        sb_rd   = 1'b1;
        sb_addr = BASE + ofs;
        @(negedge clk);
        sb_rd = 1'b0;
        d     = sb_rd_data;
        h     = sb_rd_hit;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        h;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mtrx_wr, busy, buffer_select, sb_rd_hit} !== 4'b0000 || sb_rd_data !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got wr=%b busy=%b sel=%b hit=%b rd=%h, expected 0 0 0 0 ffff",
                     mtrx_wr, busy, buffer_select, sb_rd_hit, sb_rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        sb_read(16'd7, d, h);
        checks++;
        if (h !== 1'b0 || d !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL read_out_of_range: got hit=%b data=%h, expected hit=0 data=ffff", h, d);
        end
        sb_read(16'd5, d, h);
        checks++;
        if (h !== 1'b1 || d !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_status: got hit=%b data=%h, expected hit=1 data=0000", h, d);
        end
        sb_read(16'd1, d, h);
        checks++;
        if (h !== 1'b0 || d !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL read_write_only: got hit=%b data=%h, expected hit=0 data=0000", h, d);
        end
    endtask

    task automatic test_host_write();
        logic [15:0] d;
        logic        h;
        logic [13:0] exp_addr [3];
        logic [11:0] exp_data [3];
        exp_addr[0] = 14'h3FFE; exp_addr[1] = 14'h3FFF; exp_addr[2] = 14'h0000;
        exp_data[0] = 12'h111;  exp_data[1] = 12'h222;  exp_data[2] = 12'h333;
        sb_write(16'd0, 16'h3FFE);
        for (int i = 0; i < 3; i++) begin
            sb_write(16'd1, 16'(exp_data[i]));
            checks++;
            if (mtrx_wr !== 1'b1 || mtrx_wr_addr !== exp_addr[i] || mtrx_wr_data !== exp_data[i]) begin
                failures++;
                $display("[TB] FAIL host_write_%0d: got wr=%b addr=%h data=%h, expected 1 %h %h",
                         i, mtrx_wr, mtrx_wr_addr, mtrx_wr_data, exp_addr[i], exp_data[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (mtrx_wr !== 1'b0 || mtrx_wr_addr !== 14'h0000 || mtrx_wr_data !== 12'h333) begin
            failures++;
            $display("[TB] FAIL host_write_hold: got wr=%b addr=%h data=%h, expected 0 0000 333",
                     mtrx_wr, mtrx_wr_addr, mtrx_wr_data);
        end
        sb_read(16'd0, d, h);
        checks++;
        if (h !== 1'b1 || d !== 16'h0001) begin
            failures++;
            $display("[TB] FAIL addr_wrap_readback: got hit=%b data=%h, expected 1 0001", h, d);
        end
    endtask

    task automatic test_fill_basic();
        logic [15:0] d;
        logic        h;
        sb_write(16'd0, 16'h0100);
        sb_write(16'd3, 16'h0004);
        sb_write(16'd4, 16'h0F00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mtrx_wr !== 1'b1 || busy !== 1'b1 || mtrx_wr_addr !== 14'(16'h0100 + i) || mtrx_wr_data !== 12'hF00) begin
                failures++;
                $display("[TB] FAIL fill_basic_%0d: got wr=%b busy=%b addr=%h data=%h, expected 1 1 %h f00",
                         i, mtrx_wr, busy, mtrx_wr_addr, mtrx_wr_data, 14'(16'h0100 + i));
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || mtrx_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_basic_end: got busy=%b wr=%b, expected 0 0", busy, mtrx_wr);
        end
        sb_read(16'd0, d, h);
        checks++;
        if (d !== 16'h0100) begin
            failures++;
            $display("[TB] FAIL fill_addr_kept: got %h, expected 0100", d);
        end
    endtask

    task automatic test_fill_stall();
        logic [15:0] seen;
        int          busy_cycles;
        int          fill_writes;
        int          dups;
        logic        host_ok;
        seen = '0; busy_cycles = 0; fill_writes = 0; dups = 0; host_ok = 1'b0;
        sb_write(16'd0, 16'h0200);
        sb_write(16'd3, 16'h0010);
        sb_write(16'd4, 16'h00A5);
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (busy) busy_cycles++;
            if (mtrx_wr && mtrx_wr_data == 12'h0A5) begin
                fill_writes++;
                if (mtrx_wr_addr < 14'h0200 || mtrx_wr_addr > 14'h020F) dups++;
                else if (seen[mtrx_wr_addr[3:0]]) dups++;
                else seen[mtrx_wr_addr[3:0]] = 1'b1;
            end
            if (cyc == 2 && mtrx_wr && mtrx_wr_addr == 14'h0300 && mtrx_wr_data == 12'h7E7) host_ok = 1'b1;
            if (cyc == 0) begin
                sb_wr = 1'b1; sb_addr = BASE + 16'd0; sb_wr_data = 16'h0300;
            end else if (cyc == 1) begin
                sb_wr = 1'b1; sb_addr = BASE + 16'd1; sb_wr_data = 16'h07E7;
            end else begin
                sb_wr = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (!host_ok) begin
            failures++;
            $display("[TB] FAIL stall_host_cycle: got host write seen=%b, expected 1 at 0300/7e7", host_ok);
        end
        checks++;
        if (busy_cycles != 17) begin
            failures++;
            $display("[TB] FAIL stall_duration: got %0d busy cycles, expected 17", busy_cycles);
        end
        checks++;
        if (fill_writes != 16 || seen !== 16'hFFFF || dups != 0) begin
            failures++;
            $display("[TB] FAIL stall_coverage: got writes=%0d seen=%h dups=%0d, expected 16 ffff 0",
                     fill_writes, seen, dups);
        end
    endtask

    task automatic test_fill_reject();
        logic [15:0] d;
        logic        h;
        int          writes;
        logic        order_ok;
        writes = 0; order_ok = 1'b1;
        sb_write(16'd0, 16'h0400);
        sb_write(16'd3, 16'h0008);
        sb_write(16'd4, 16'h0123);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (mtrx_wr) begin
                if (mtrx_wr_addr !== 14'(16'h0400 + writes) || mtrx_wr_data !== 12'h123) order_ok = 1'b0;
                writes++;
            end
            if (cyc == 1) begin
                sb_wr = 1'b1; sb_addr = BASE + 16'd4; sb_wr_data = 16'h0456;
            end else begin
                sb_wr = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (writes != 8 || !order_ok) begin
            failures++;
            $display("[TB] FAIL reject_no_restart: got writes=%0d in_order=%b, expected 8 1", writes, order_ok);
        end
        sb_read(16'd5, d, h);
        checks++;
        if (d !== 16'h0008) begin
            failures++;
            $display("[TB] FAIL reject_sticky: got status=%h, expected 0008", d);
        end
        sb_read(16'd5, d, h);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reject_clear: got status=%h, expected 0000", d);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        logic        h;
        sb_write(16'd0, 16'h0055);
        sb_wr = 1'b1; sb_rd = 1'b1; sb_addr = BASE; sb_wr_data = 16'h0AAA;
        @(negedge clk);
        sb_wr = 1'b0; sb_rd = 1'b0;
        checks++;
        if (sb_rd_hit !== 1'b1 || sb_rd_data !== 16'h0055) begin
            failures++;
            $display("[TB] FAIL rd_wr_same_cycle: got hit=%b data=%h, expected 1 0055", sb_rd_hit, sb_rd_data);
        end
        sb_read(16'd0, d, h);
        checks++;
        if (d !== 16'h0AAA) begin
            failures++;
            $display("[TB] FAIL rd_wr_after: got %h, expected 0aaa", d);
        end
    endtask

    task automatic test_swap();
        logic [15:0] d;
        logic        h;
        int          fall;
        logic        early;
        fall = -1; early = 1'b0;
        sb_write(16'd0, 16'h0500);
        sb_write(16'd3, 16'h0006);
        sb_write(16'd4, 16'h0ABC);
        sb_write(16'd2, 16'h0001);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (fall < 0 && busy && buffer_select !== 1'b0) early = 1'b1;
            if (fall < 0 && !busy) begin
                fall = cyc;
                checks++;
                if (buffer_select !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL swap_at_fall: got sel=%b, expected 0", buffer_select);
                end
            end else if (fall >= 0 && cyc == fall + 1) begin
                checks++;
                if (buffer_select !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL swap_after_fall: got sel=%b, expected 1", buffer_select);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (early || fall != 5) begin
            failures++;
            $display("[TB] FAIL swap_deferred: got early=%b fall_cycle=%0d, expected 0 5", early, fall);
        end
        sb_read(16'd2, d, h);
        checks++;
        if (h !== 1'b1 || d !== 16'h0005) begin
            failures++;
            $display("[TB] FAIL select_pending: got hit=%b data=%h, expected 1 0005", h, d);
        end
        buffer_current = 1'b1;
        @(negedge clk);
        sb_read(16'd5, d, h);
        checks++;
        if (d !== 16'h0004) begin
            failures++;
            $display("[TB] FAIL swap_done_status: got %h, expected 0004", d);
        end
        sb_read(16'd2, d, h);
        checks++;
        if (d !== 16'h0003) begin
            failures++;
            $display("[TB] FAIL swap_done_select: got %h, expected 0003", d);
        end
    endtask

    task automatic test_fill_full();
        int   busy_cycles;
        int   writes;
        logic addr_ok;
        busy_cycles = 0; writes = 0; addr_ok = 1'b1;
        sb_write(16'd0, 16'h3FF0);
        sb_write(16'd3, 16'h0000);
        sb_write(16'd4, 16'h0777);
        for (int cyc = 0; cyc < 17000 && busy; cyc++) begin
            busy_cycles++;
            if (mtrx_wr) begin
                if (mtrx_wr_addr !== 14'(16'h3FF0 + writes)) addr_ok = 1'b0;
                writes++;
            end
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != 16384 || writes != 16384 || !addr_ok || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_full_frame: got busy_cycles=%0d writes=%0d addr_ok=%b busy=%b, expected 16384 16384 1 0",
                     busy_cycles, writes, addr_ok, busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        int late_writes;
        late_writes = 0;
        sb_write(16'd0, 16'h0600);
        sb_write(16'd3, 16'h000A);
        sb_write(16'd4, 16'h0321);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mtrx_wr !== 1'b0 || busy !== 1'b0 || sb_rd_data !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL reset_mid_fill: got wr=%b busy=%b rd=%h, expected 0 0 ffff",
                     mtrx_wr, busy, sb_rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (mtrx_wr || busy) late_writes++;
        end
        checks++;
        if (late_writes != 0) begin
            failures++;
            $display("[TB] FAIL reset_no_resume: got %0d active cycles, expected 0", late_writes);
        end
    endtask

    initial begin
        rst            = 1'b1;
        sb_wr          = 1'b0;
        sb_rd          = 1'b0;
        sb_addr        = 16'h0000;
        sb_wr_data     = 16'h0000;
        buffer_current = 1'b0;
        @(negedge clk);
        test_reset();
        test_host_write();
        test_fill_basic();
        test_fill_stall();
        test_fill_reject();
        test_simultaneous();
        test_swap();
        test_fill_full();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
